demux_l2: RTL and testbench
===========================

# demux_l2

Layer-2 1:4 byte demultiplexer, the receive-side counterpart of the 4:1 lane mux. It accepts a serialized byte stream (one byte slot per clock at the 4f rate, lane order 0,1,2,3) with a per-slot valid. It reassembles each group of four slots into a frame and presents all four lanes and their valids at once, held stable for a full frame (the f rate). It sits between the serial-to-parallel converter and the per-lane FIFOs.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of each lane and of the input stream.

Ports:
- clk_4f  in  1  single clock; one input slot per rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the clk_4f rising edge.
- Entrada  in  DATA_WIDTH  serialized input byte for the current slot.
- validEntrada  in  1  current slot carries valid data.
- Salida0..Salida3  out  DATA_WIDTH each  lane bytes of the last committed frame.
- validSalida0..validSalida3  out  1 each  lane valids of the last committed frame.
- frame_strobe  out  1  one-cycle pulse, high the cycle the outputs are updated.
- slot  out  2  current slot index; exposed for debug and bench alignment.

## Operation
- Slot counter `slot`:
  - Reset to 0.
  - Increments by 1 every cycle, unconditionally, and wraps 3→0.
  - The slot position, not the valid, defines the lane. An invalid slot still consumes its lane.
- Shadow stage: four shadow data registers and four shadow valid bits, one per lane.
  - Each cycle, lane `slot` is written.
  - validEntrada=1: shadow data = Entrada, shadow valid = 1.
  - validEntrada=0: shadow data holds its previous value, shadow valid = 0.
- Commit, on cycles with slot==3:
  - Shadow lanes 0..2 and the current input for lane 3 (same valid rule as above) are copied to Salida0..3 / validSalida0..3.
  - frame_strobe = 1 on the following cycle, aligned with the new outputs.
- Outputs change only on a commit. They are held for exactly 4 cycles between commits.
- Reset values: slot=0; Salida0..3=0; validSalida0..3=0; frame_strobe=0; shadow data and valid=0.
- Reset mid-frame: the partial frame is discarded, with no commit. After reset deasserts, the first sampled slot is lane 0.
- Reset asserted on a slot==3 cycle: reset wins; no commit occurs.
- No backpressure. The consumer must sample on frame_strobe or within the 4-cycle hold window.

## Timing
- Slot k of a frame is sampled at edge n+k (k=0..3).
- Outputs and frame_strobe update at edge n+4, i.e. one cycle after the lane-3 slot.
- Latency by lane: lane 0 byte to output = 4 cycles; lane 3 byte to output = 1 cycle.
- frame_strobe is high for 1 of every 4 cycles in steady state.
  - First strobe: 4 cycles after reset is released (edge with slot==3 at cycle 3, strobe at cycle 4).
- Arithmetic: slot is a 2-bit counter with natural wrap. Data is passed through untouched; no width conversion.

## Structure
- Shared package (alongside the mux): lane count LANES=4, SLOT_W=2, default DATA_WIDTH=8, and the lane-index constants LANE0..LANE3.
  - The mux and demux must agree on lane order from these constants.
- One natural sub-module: `demux_slot_counter`, the 2-bit wrapping counter with synchronous reset and a `last_slot` output (slot==3) used as the commit enable.
- The shadow and output registers live in demux_l2.

## Test plan
- Reset hold:
  - Stimulus: reset=1 for 3 cycles with Entrada=8'hAA, validEntrada=1.
  - Required response: all Salida=0, all validSalida=0, frame_strobe=0, slot=0 throughout.
- Full valid frame:
  - Stimulus: after reset, slots EE,01,FF,FD all valid.
  - Required response: 4 cycles after release, Salida0..3=EE,01,FF,FD, validSalida=1111, frame_strobe pulse of 1 cycle; values held 4 cycles.
- Invalid slot:
  - Stimulus: next frame EF,02,(invalid, Entrada=00),FE.
  - Required response: Salida=EF,02,FF,FE, validSalida0..3=1,1,0,1. Lane 2 data holds FF with valid 0.
- Back-to-back frames:
  - Stimulus: 3 consecutive frames with incrementing bytes.
  - Required response: strobes exactly 4 cycles apart; each frame's lanes appear unchanged, in order.
- Reset mid-frame:
  - Stimulus: assert reset at slot 2 of a frame after lanes 0,1 = 11,22.
  - Required response: no commit, outputs all 0. The next frame, restarted at lane 0 with 33,44,55,66, outputs exactly 33,44,55,66.
- Wrap check:
  - Stimulus: run 1000 cycles with random data and valids.
  - Required response: slot sequence is 0,1,2,3 repeating. The scoreboard re-serializes the outputs, and the result matches the input stream for every valid slot.

Source files
------------

// File: rtl/demux_l2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_l2_pkg
//  Description : Shared lane constants for the layer-2 lane mux/demux pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_l2_pkg;

    localparam int LANES          = 4;
    localparam int SLOT_W         = 2;
    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [SLOT_W-1:0] slot_t;

    // Lane order on the wire; the mux serializes in this same order.
    localparam slot_t LANE0 = 2'd0;
    localparam slot_t LANE1 = 2'd1;
    localparam slot_t LANE2 = 2'd2;
    localparam slot_t LANE3 = 2'd3;

endpackage : demux_l2_pkg
`default_nettype wire

// File: rtl/demux_l2_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_l2_if
//  Description : Serial byte input and committed 4-lane frame output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_l2_if
    import demux_l2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] Entrada;
    logic                  validEntrada;
    logic [DATA_WIDTH-1:0] Salida0;
    logic [DATA_WIDTH-1:0] Salida1;
    logic [DATA_WIDTH-1:0] Salida2;
    logic [DATA_WIDTH-1:0] Salida3;
    logic                  validSalida0;
    logic                  validSalida1;
    logic                  validSalida2;
    logic                  validSalida3;
    logic                  frame_strobe;
    slot_t                 slot;

    modport master (
        output Entrada, validEntrada,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validSalida0, validSalida1, validSalida2, validSalida3,
        input  frame_strobe, slot
    );

    modport slave (
        input  Entrada, validEntrada,
        output Salida0, Salida1, Salida2, Salida3,
        output validSalida0, validSalida1, validSalida2, validSalida3,
        output frame_strobe, slot
    );

endinterface : demux_l2_if
`default_nettype wire

// File: rtl/demux_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot_counter
//  Description : Free-running 2-bit lane slot counter with last-slot flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot_counter
    import demux_l2_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    output slot_t     o_slot,
    output logic      o_last_slot
);

    slot_t r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= LANE0;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    assign o_slot      = r_slot;
    assign o_last_slot = (r_slot == LANE3);

endmodule : demux_slot_counter
`default_nettype wire

// File: rtl/demux_l2.sv
`default_nettype none
// ============================================================================
//  Module      : demux_l2
//  Description : 1:4 byte demultiplexer; reassembles four serial slots into
//                one frame held stable for four clk_4f cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_l2
    import demux_l2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  wire logic  clk_4f,
    input  wire logic  reset,
    demux_l2_if.slave  bus
);

    slot_t                 w_slot;
    logic                  w_last_slot;

    logic [DATA_WIDTH-1:0] r_salida0;
    logic [DATA_WIDTH-1:0] r_salida1;
    logic [DATA_WIDTH-1:0] r_salida2;
    logic [DATA_WIDTH-1:0] r_salida3;
    logic [LANES-1:0]      r_valid_out;
    logic                  r_frame_strobe;

    demux_slot_counter u_slot_counter (
        .clk         (clk_4f),
        .rst         (reset),
        .o_slot      (w_slot),
        .o_last_slot (w_last_slot)
    );

    // Lane 3 needs no shadow: it is taken straight from the input at commit,
    // and an invalid lane-3 slot simply leaves its output data untouched.
    for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_shadow
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        always_ff @(posedge clk_4f) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_slot == SLOT_W'(gi)) begin
                if (bus.validEntrada) begin
                    r_data <= bus.Entrada;
                end
                r_valid <= bus.validEntrada;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_salida0      <= '0;
            r_salida1      <= '0;
            r_salida2      <= '0;
            r_salida3      <= '0;
            r_valid_out    <= '0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_frame_strobe <= w_last_slot;
            if (w_last_slot) begin
                r_salida0          <= g_shadow[LANE0].r_data;
                r_salida1          <= g_shadow[LANE1].r_data;
                r_salida2          <= g_shadow[LANE2].r_data;
                r_valid_out[LANE0] <= g_shadow[LANE0].r_valid;
                r_valid_out[LANE1] <= g_shadow[LANE1].r_valid;
                r_valid_out[LANE2] <= g_shadow[LANE2].r_valid;
                r_valid_out[LANE3] <= bus.validEntrada;
                if (bus.validEntrada) begin
                    r_salida3 <= bus.Entrada;
                end
            end
        end
    end

    assign bus.Salida0      = r_salida0;
    assign bus.Salida1      = r_salida1;
    assign bus.Salida2      = r_salida2;
    assign bus.Salida3      = r_salida3;
    assign bus.validSalida0 = r_valid_out[LANE0];
    assign bus.validSalida1 = r_valid_out[LANE1];
    assign bus.validSalida2 = r_valid_out[LANE2];
    assign bus.validSalida3 = r_valid_out[LANE3];
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.slot         = w_slot;

endmodule : demux_l2
`default_nettype wire

// File: tb/tb_demux_l2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_l2
//  Description : Directed and randomized self-checking bench for demux_l2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_l2;

    logic clk_4f;
    logic reset;
    int   n_err;
    int   n_checks;

    demux_l2_if #(.DATA_WIDTH(8)) bus ();

    demux_l2 #(.DATA_WIDTH(8)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    logic [31:0] w_out;
    logic [3:0]  w_vout;
    assign w_out  = {bus.Salida0, bus.Salida1, bus.Salida2, bus.Salida3};
    assign w_vout = {bus.validSalida0, bus.validSalida1, bus.validSalida2, bus.validSalida3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one slot at the falling edge; return after the next falling edge.
    task automatic cyc(input logic rst_v, input logic [7:0] d, input logic v);
        reset            = rst_v;
        bus.Entrada      = d;
        bus.validEntrada = v;
        @(posedge clk_4f);
        @(negedge clk_4f);
    endtask

    // One full frame, lane 0 first (d[31:24]). Outputs must hold the previous
    // frame for three slots, then show the new frame with a strobe.
    task automatic frame4(input string tag, input logic [31:0] d, input logic [3:0] v,
                          input logic [31:0] hold_d, input logic [3:0] hold_v,
                          input logic [31:0] exp_d, input logic [3:0] exp_v);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, d[31-8*k -: 8], v[3-k]);
            if (k < 3) begin
                chk({tag, "_hold_data"},  w_out, hold_d);
                chk({tag, "_hold_valid"}, {28'd0, w_vout}, {28'd0, hold_v});
                chk({tag, "_no_strobe"},  {31'd0, bus.frame_strobe}, 32'd0);
                chk({tag, "_slot"},       {30'd0, bus.slot}, 32'(k + 1));
            end else begin
                chk({tag, "_data"},   w_out, exp_d);
                chk({tag, "_valid"},  {28'd0, w_vout}, {28'd0, exp_v});
                chk({tag, "_strobe"}, {31'd0, bus.frame_strobe}, 32'd1);
                chk({tag, "_slot0"},  {30'd0, bus.slot}, 32'd0);
            end
        end
    endtask

    logic [7:0] r_in_d [4];
    logic       r_in_v [4];

    initial begin
        n_err            = 0;
        n_checks         = 0;
        reset            = 1'b1;
        bus.Entrada      = 8'h00;
        bus.validEntrada = 1'b0;
        @(negedge clk_4f);

        // Reset hold with live input
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hAA, 1'b1);
            chk("rst_data",   w_out, 32'd0);
            chk("rst_valid",  {28'd0, w_vout}, 32'd0);
            chk("rst_strobe", {31'd0, bus.frame_strobe}, 32'd0);
            chk("rst_slot",   {30'd0, bus.slot}, 32'd0);
        end

        frame4("full",  32'hEE01FFFD, 4'b1111, 32'h0, 4'b0000, 32'hEE01FFFD, 4'b1111);
        frame4("inval", 32'hEF0200FE, 4'b1101, 32'hEE01FFFD, 4'b1111, 32'hEF02FFFE, 4'b1101);
        frame4("b2b0",  32'h10111213, 4'b1111, 32'hEF02FFFE, 4'b1101, 32'h10111213, 4'b1111);
        frame4("b2b1",  32'h14151617, 4'b1111, 32'h10111213, 4'b1111, 32'h14151617, 4'b1111);
        frame4("b2b2",  32'h18191A1B, 4'b1111, 32'h14151617, 4'b1111, 32'h18191A1B, 4'b1111);

        // Reset at slot 2 discards the partial frame
        cyc(1'b0, 8'h11, 1'b1);
        cyc(1'b0, 8'h22, 1'b1);
        chk("mid_pre_slot", {30'd0, bus.slot}, 32'd2);
        cyc(1'b1, 8'h77, 1'b1);
        chk("mid_rst_data",   w_out, 32'd0);
        chk("mid_rst_valid",  {28'd0, w_vout}, 32'd0);
        chk("mid_rst_strobe", {31'd0, bus.frame_strobe}, 32'd0);
        chk("mid_rst_slot",   {30'd0, bus.slot}, 32'd0);

        // Reset on the slot-3 cycle beats the commit
        cyc(1'b0, 8'hA1, 1'b1);
        cyc(1'b0, 8'hA2, 1'b1);
        cyc(1'b0, 8'hA3, 1'b1);
        cyc(1'b1, 8'hA4, 1'b1);
        chk("s3_rst_data",   w_out, 32'd0);
        chk("s3_rst_valid",  {28'd0, w_vout}, 32'd0);
        chk("s3_rst_strobe", {31'd0, bus.frame_strobe}, 32'd0);
        chk("s3_rst_slot",   {30'd0, bus.slot}, 32'd0);

        frame4("post_rst", 32'h33445566, 4'b1111, 32'h0, 4'b0000, 32'h33445566, 4'b1111);

        // Random stream: re-serialize each committed frame against its inputs
        for (int f = 0; f < 250; f++) begin
            for (int k = 0; k < 4; k++) begin
                r_in_d[k] = 8'($urandom);
                r_in_v[k] = 1'($urandom_range(0, 1));
                cyc(1'b0, r_in_d[k], r_in_v[k]);
                chk("rnd_slot", {30'd0, bus.slot}, 32'((k + 1) % 4));
                chk("rnd_strobe", {31'd0, bus.frame_strobe}, (k == 3) ? 32'd1 : 32'd0);
            end
            chk("rnd_valid", {28'd0, w_vout},
                {28'd0, r_in_v[0], r_in_v[1], r_in_v[2], r_in_v[3]});
            if (r_in_v[0]) chk("rnd_lane0", {24'd0, bus.Salida0}, {24'd0, r_in_d[0]});
            if (r_in_v[1]) chk("rnd_lane1", {24'd0, bus.Salida1}, {24'd0, r_in_d[1]});
            if (r_in_v[2]) chk("rnd_lane2", {24'd0, bus.Salida2}, {24'd0, r_in_d[2]});
            if (r_in_v[3]) chk("rnd_lane3", {24'd0, bus.Salida3}, {24'd0, r_in_d[3]});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_demux_l2
`default_nettype wire
